spram_echo_ctrl: RTL and testbench
==================================

// Module: spram_echo_ctrl
// PURPOSE
// - Initiator side of the 4-bank SPRAM memory block: drives its addr/datain/wren, consumes its dataout.
// - Implements a circular audio delay line with feedback: per input sample, reads the sample D slots back,
//   writes saturate(in + delayed>>>FB_SHIFT), emits delayed sample. Sits between codec RX and mixer/TX.
// PARAMETERS
// - MEMLEN    16  address width of the memory block (64K words; bits [15:14] select bank)
// - DATALEN   16  sample width, signed two's complement
// - FB_SHIFT   1  feedback attenuation, arithmetic right shift applied to delayed sample
// - CLEAR_ON_RESET 1  1: zero all 2^MEMLEN words after reset release; 0: skip clear
// PORTS
// - clk          in   1        system clock, same clock as memory block
// - resetn       in   1        asynchronous, active-low reset
// - sample_in    in   DATALEN  input sample, valid with sample_valid
// - sample_valid in   1        one-cycle strobe, new input sample
// - delay        in   MEMLEN   delay in samples; 0 means 2^MEMLEN; sampled when sample accepted
// - fb_en        in   1        1: add feedback into written sample; 0: write sample_in unchanged
// - ready        out  1        high in IDLE only (not clearing, not busy)
// - out_sample   out  DATALEN  delayed sample, held until next update
// - out_valid    out  1        one-cycle strobe, out_sample updated
// - overrun      out  1        one-cycle pulse, sample_valid seen while not ready (sample dropped)
// - mem_addr     out  MEMLEN   memory address
// - mem_datain   out  DATALEN  memory write data
// - mem_dataout  in   DATALEN  memory read data, registered by SPRAM (1-cycle), bank mux combinational on mem_addr
// - mem_wren     out  1        memory write enable
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0 (ready=0), wr_ptr=0, state CLEAR (or IDLE if CLEAR_ON_RESET=0).
// - States: CLEAR -> IDLE -> RD -> RDCAP -> WR -> IDLE.
// - CLEAR: mem_wren=1, mem_datain=0, mem_addr=clr_cnt, clr_cnt++ each cycle; after addr 2^MEMLEN-1 -> IDLE.
// - IDLE: ready=1, mem_wren=0. On sample_valid: latch sample_in, fb_en; rd_addr = wr_ptr - delay (mod 2^MEMLEN) -> RD.
// - RD: mem_addr=rd_addr, mem_wren=0 -> RDCAP.
// - RDCAP: mem_addr held at rd_addr (bank mux must still select read bank); at edge capture mem_dataout -> dly_q -> WR.
// - WR: mem_addr=wr_ptr, mem_wren=1, mem_datain = fb ? sat(sample + (dly_q>>>FB_SHIFT)) : sample.
//   At edge: wr_ptr++ (wraps 2^MEMLEN-1 -> 0), out_sample<=dly_q, out_valid<=1 -> IDLE.
// - Latency: sample_valid accepted at edge N -> out_valid high cycle after edge N+3 (4 cycles); max rate 1 sample / 4 clk.
// - Saturation: sum in DATALEN+1 bits; >2^(DATALEN-1)-1 -> 0x7FFF, < -2^(DATALEN-1) -> 0x8000 (DATALEN=16).
// - delay=0: rd_addr = wr_ptr -> reads word written 2^MEMLEN samples ago (maximum delay).
// - sample_valid when state != IDLE (incl. CLEAR): sample dropped, overrun pulse next cycle, FSM unaffected.
// - sample_valid in IDLE same cycle as a pending out_valid: accepted normally.
// - mem_wren is 0 in every state except CLEAR and WR; never glitches between states (registered or decoded from state reg).
// - Reset mid-operation: FSM aborts immediately; partial write not retried; wr_ptr back to 0; clear re-runs.
// STRUCTURE
// - Shared package echo_pkg: state encoding localparams, sat_add function, MEMLEN/DATALEN defaults.
// - One sub-module: echo_sat_add (combinational shift + saturating add, parametrised DATALEN/FB_SHIFT).
// - Remainder: FSM, wr_ptr/clr_cnt counters, sample/delay latches in this module.
// TESTING (bench uses behavioural model of memory block; CLEAR_ON_RESET=1 unless noted)
// - Reset release -> ready=0 for 65536 cycles, mem_wren=1 with addr 0..0xFFFF, datain=0; then ready=1.
// - delay=3, fb_en=0, samples 0x0100,0x0200,0x0300,0x0400 -> out 0,0,0,0x0100; out_valid 4 clk after each strobe.
// - fb_en=1, FB_SHIFT=1, delay=1, samples 0x4000,0x7000 -> mem[1]=0x7FFF (0x7000+0x2000 saturates); out=0x4000.
// - Negative saturation: delayed=0x8000, in=0x8000, fb_en=1 -> written 0x8000; no wrap to positive.
// - Wrap: CLEAR_ON_RESET=0, force wr_ptr near 0xFFFF via 65535 samples, delay=2 -> rd_addr wraps to 0xFFFE/0xFFFF, bank 3 data read back.
// - sample_valid one cycle after accept -> dropped, overrun pulses once; assert resetn low in RDCAP -> outputs 0, clear restarts.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared definitions for the SPRAM echo/delay-line controller: default widths,
// FSM state encoding and the saturating adder used on the feedback path.
package echo_pkg;

    localparam int MEMLEN_DEF  = 16;
    localparam int DATALEN_DEF = 16;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD    = 3'd2,
        ST_RDCAP = 3'd3,
        ST_WR    = 3'd4
    } state_t;

    // Adds two sign-extended operands and clamps the sum to a w-bit signed range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = {a[31], a} + {b[31], b};
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi[31:0];
        end else if (sum < lo) begin
            return lo[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/spram_echo_ctrl_if.sv
// Word-wide bus between the echo controller (master) and the 4-bank SPRAM block (slave).
interface spram_echo_ctrl_if
    import echo_pkg::*;
#(
    parameter int MEMLEN  = MEMLEN_DEF,
    parameter int DATALEN = DATALEN_DEF
);
    logic        [MEMLEN-1:0]  addr;
    logic signed [DATALEN-1:0] datain;
    logic signed [DATALEN-1:0] dataout;
    logic                      wren;

    modport master (output addr, output datain, output wren, input dataout);
    modport slave  (input addr, input datain, input wren, output dataout);

endinterface

// File: rtl/echo_sat_add.sv
// Feedback mixer: attenuates the delayed sample by an arithmetic shift and adds it
// to the new sample with saturation; passes the sample through when feedback is off.
module echo_sat_add
    import echo_pkg::*;
#(
    parameter int DATALEN  = DATALEN_DEF,
    parameter int FB_SHIFT = 1
) (
    input  logic signed [DATALEN-1:0] sample,
    input  logic signed [DATALEN-1:0] delayed,
    input  logic                      fb_en,
    output logic signed [DATALEN-1:0] result
);

    logic signed [DATALEN-1:0] dly_sh;

    assign dly_sh = delayed >>> FB_SHIFT;
    assign result = fb_en ? DATALEN'(sat_add(32'(sample), 32'(dly_sh), DATALEN)) : sample;

endmodule

// File: rtl/spram_echo_ctrl.sv
// Circular audio delay line with feedback on top of the single-port SPRAM block:
// one read and one write per accepted sample, four clocks per sample.
module spram_echo_ctrl
    import echo_pkg::*;
#(
    parameter int MEMLEN         = MEMLEN_DEF,
    parameter int DATALEN        = DATALEN_DEF,
    parameter int FB_SHIFT       = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic signed [DATALEN-1:0] sample_in,
    input  logic                      sample_valid,
    input  logic        [MEMLEN-1:0]  delay,
    input  logic                      fb_en,
    output logic                      ready,
    output logic signed [DATALEN-1:0] out_sample,
    output logic                      out_valid,
    output logic                      overrun,
    spram_echo_ctrl_if.master         mem
);

    localparam state_t RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t state;
    state_t state_nxt;
    // Low while reset is held and for the first edge after release, so every
    // output (including the memory strobes) reads 0 during reset.
    logic   run;

    logic        [MEMLEN-1:0]  clr_cnt;
    logic        [MEMLEN-1:0]  wr_ptr;
    logic        [MEMLEN-1:0]  rd_addr_p0;
    logic signed [DATALEN-1:0] sample_p0;
    logic                      fb_p0;
    logic signed [DATALEN-1:0] dly_p1;
    logic signed [DATALEN-1:0] wr_data;
    logic                      accept;

    assign accept = ready & sample_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RESET_ST;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (run) begin
            case (state)
                ST_CLEAR: if (clr_cnt == '1) state_nxt = ST_IDLE;
                ST_IDLE:  if (sample_valid) state_nxt = ST_RD;
                ST_RD:    state_nxt = ST_RDCAP;
                ST_RDCAP: state_nxt = ST_WR;
                ST_WR:    state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // The read address stays on the bus through RDCAP: the SPRAM bank mux is
    // combinational on addr and must still select the bank being read.
    always_comb begin
        ready      = 1'b0;
        mem.wren   = 1'b0;
        mem.addr   = '0;
        mem.datain = '0;
        if (run) begin
            case (state)
                ST_CLEAR: begin
                    mem.wren = 1'b1;
                    mem.addr = clr_cnt;
                end
                ST_IDLE:  ready = 1'b1;
                ST_RD,
                ST_RDCAP: mem.addr = rd_addr_p0;
                ST_WR: begin
                    mem.wren   = 1'b1;
                    mem.addr   = wr_ptr;
                    mem.datain = wr_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_cnt    <= '0;
            wr_ptr     <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= (state == ST_WR);
            overrun   <= sample_valid & ~ready;
            if (run && state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (state == ST_WR) begin
                wr_ptr     <= wr_ptr + 1'b1;
                out_sample <= dly_p1;
            end
        end
    end

    // p0: sample accepted in IDLE (delay subtraction wraps modulo 2^MEMLEN)
    always_ff @(posedge clk) begin
        if (accept) begin
            sample_p0  <= sample_in;
            fb_p0      <= fb_en;
            rd_addr_p0 <= wr_ptr - delay;
        end
    end

    // p1: delayed word captured from SPRAM at the end of RDCAP
    always_ff @(posedge clk) begin
        if (state == ST_RDCAP) dly_p1 <= mem.dataout;
    end

    echo_sat_add #(
        .DATALEN  (DATALEN),
        .FB_SHIFT (FB_SHIFT)
    ) u_sat_add (
        .sample  (sample_p0),
        .delayed (dly_p1),
        .fb_en   (fb_p0),
        .result  (wr_data)
    );

endmodule

// File: tb/tb_spram_echo_ctrl.sv
// Bench for spram_echo_ctrl: full-size instance with clear, plus a 64-word
// instance without clear for pointer wrap, each against a 4-bank SPRAM model.
module tb_spram_echo_ctrl;
    import echo_pkg::*;

    localparam int ML  = 16;
    localparam int ML2 = 6;
    localparam int DL  = 16;

    typedef struct {
        logic [15:0] smp;
        logic [15:0] dly;
        logic        fb;
        logic [15:0] exp_out;
        logic [15:0] exp_wr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn, resetn2;
    logic [DL-1:0] s_in1, s_in2, osmp1, osmp2;
    logic [ML-1:0] dly1;
    logic [ML2-1:0] dly2;
    logic          s_vld1, s_vld2, fb1, fb2;
    logic          rdy1, rdy2, ovld1, ovld2, ovr1, ovr2;

    int checks = 0;
    int errors = 0;

    spram_echo_ctrl_if #(.MEMLEN(ML),  .DATALEN(DL)) mif1 ();
    spram_echo_ctrl_if #(.MEMLEN(ML2), .DATALEN(DL)) mif2 ();

    spram_echo_ctrl #(.MEMLEN(ML), .DATALEN(DL), .FB_SHIFT(1), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .sample_in(s_in1), .sample_valid(s_vld1), .delay(dly1),
        .fb_en(fb1), .ready(rdy1), .out_sample(osmp1), .out_valid(ovld1), .overrun(ovr1),
        .mem(mif1.master));

    spram_echo_ctrl #(.MEMLEN(ML2), .DATALEN(DL), .FB_SHIFT(1), .CLEAR_ON_RESET(1'b0)) dut2 (
        .clk(clk), .resetn(resetn2), .sample_in(s_in2), .sample_valid(s_vld2), .delay(dly2),
        .fb_en(fb2), .ready(rdy2), .out_sample(osmp2), .out_valid(ovld2), .overrun(ovr2),
        .mem(mif2.master));

    // SPRAM model: each bank registers its read word, output mux follows addr[top:top-1]
    logic [DL-1:0] mem1 [0:(1<<ML)-1];
    logic [DL-1:0] bq1  [0:3];
    logic [DL-1:0] mem2 [0:(1<<ML2)-1];
    logic [DL-1:0] bq2  [0:3];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) bq1[b] <= mem1[{b[1:0], mif1.addr[ML-3:0]}];
        if (mif1.wren) mem1[mif1.addr] <= mif1.datain;
    end
    assign mif1.dataout = bq1[mif1.addr[ML-1 -: 2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) bq2[b] <= mem2[{b[1:0], mif2.addr[ML2-3:0]}];
        if (mif2.wren) mem2[mif2.addr] <= mif2.datain;
    end
    assign mif2.dataout = bq2[mif2.addr[ML2-1 -: 2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe one sample into dut1 and check the write cycle and the 4-clock output.
    task automatic apply1(input int idx, input vec_t v, input logic [15:0] wp);
        logic lat_ok;
        s_in1 = v.smp; dly1 = v.dly; fb1 = v.fb; s_vld1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_vld1 = 1'b0;
        lat_ok = (ovld1 == 1'b0) && (rdy1 == 1'b0);
        @(negedge clk);
        lat_ok = lat_ok && (ovld1 == 1'b0);
        @(negedge clk);
        check($sformatf("v%0d_wr_en", idx),   {31'd0, mif1.wren}, 32'd1);
        check($sformatf("v%0d_wr_addr", idx), {16'd0, mif1.addr}, {16'd0, wp});
        check($sformatf("v%0d_wr_data", idx), {16'd0, mif1.datain}, {16'd0, v.exp_wr});
        @(negedge clk);
        check($sformatf("v%0d_out_valid", idx), {31'd0, ovld1 & lat_ok}, 32'd1);
        check($sformatf("v%0d_out_sample", idx), {16'd0, osmp1}, {16'd0, v.exp_out});
    endtask

    task automatic send2(input logic [15:0] smp, input logic [ML2-1:0] d,
                         output logic [15:0] o, output logic v);
        s_in2 = smp; dly2 = d; fb2 = 1'b0; s_vld2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_vld2 = 1'b0;
        repeat (3) @(negedge clk);
        o = osmp2;
        v = ovld2;
    endtask

    initial begin
        vec_t tbl [13];
        vec_t ov;
        logic [15:0] wp;

        tbl[0]  = '{16'h0100, 16'd3, 1'b0, 16'h0000, 16'h0100};
        tbl[1]  = '{16'h0200, 16'd3, 1'b0, 16'h0000, 16'h0200};
        tbl[2]  = '{16'h0300, 16'd3, 1'b0, 16'h0000, 16'h0300};
        tbl[3]  = '{16'h0400, 16'd3, 1'b0, 16'h0100, 16'h0400};
        tbl[4]  = '{16'h4000, 16'd1, 1'b1, 16'h0400, 16'h4200};
        tbl[5]  = '{16'h7000, 16'd1, 1'b1, 16'h4200, 16'h7FFF};
        tbl[6]  = '{16'h8000, 16'd1, 1'b0, 16'h7FFF, 16'h8000};
        tbl[7]  = '{16'h8000, 16'd1, 1'b1, 16'h8000, 16'h8000};
        tbl[8]  = '{16'hF000, 16'd1, 1'b1, 16'h8000, 16'hB000};
        tbl[9]  = '{16'h1234, 16'd0, 1'b1, 16'h0000, 16'h1234};
        tbl[10] = '{16'h0001, 16'd6, 1'b1, 16'h4200, 16'h2101};
        tbl[11] = '{16'h0000, 16'd1, 1'b1, 16'h2101, 16'h1080};
        tbl[12] = '{16'h77BF, 16'd1, 1'b1, 16'h1080, 16'h7FFF};

        resetn = 1'b0; resetn2 = 1'b0;
        s_in1 = '0; dly1 = '0; fb1 = 1'b0; s_vld1 = 1'b0;
        s_in2 = '0; dly2 = '0; fb2 = 1'b0; s_vld2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready",      {31'd0, rdy1},  32'd0);
        check("rst_out_valid",  {31'd0, ovld1}, 32'd0);
        check("rst_overrun",    {31'd0, ovr1},  32'd0);
        check("rst_out_sample", {16'd0, osmp1}, 32'd0);
        check("rst_wren",       {31'd0, mif1.wren}, 32'd0);
        check("rst_addr",       {16'd0, mif1.addr}, 32'd0);
        check("rst_ready_noclr", {31'd0, rdy2}, 32'd0);
        resetn = 1'b1; resetn2 = 1'b1;

        fork
            begin
                int bad;
                bad = 0;
                @(posedge clk);
                for (int i = 0; i < (1 << ML); i++) begin
                    @(negedge clk);
                    if (mif1.wren !== 1'b1 || mif1.addr !== i[15:0] || mif1.datain !== '0
                        || rdy1 !== 1'b0) bad++;
                    if (i == 101) check("overrun_in_clear", {31'd0, ovr1}, 32'd1);
                    if (i == 102) check("overrun_one_pulse", {31'd0, ovr1}, 32'd0);
                    s_vld1 = (i == 100);
                end
                check("clear_sweep_bad_cycles", bad, 0);
                @(negedge clk);
                check("ready_after_clear", {31'd0, rdy1}, 32'd1);
                check("wren_idle", {31'd0, mif1.wren}, 32'd0);
            end
            begin
                int mism;
                logic [15:0] o;
                logic v;
                mism = 0;
                @(posedge clk);
                @(negedge clk);
                check("ready_no_clear", {31'd0, rdy2}, 32'd1);
                for (int k = 0; k < (1 << ML2); k++) begin
                    send2(16'h1000 + 16'(k), 6'd1, o, v);
                    if (!v || (k > 0 && o !== 16'h1000 + 16'(k - 1))) mism++;
                end
                check("fill_mismatches", mism, 0);
                send2(16'h2222, 6'd2, o, v);
                check("wrap_rd_3e", {15'd0, v, o}, {15'd0, 1'b1, 16'h103E});
                send2(16'h3333, 6'd2, o, v);
                check("wrap_rd_3f", {15'd0, v, o}, {15'd0, 1'b1, 16'h103F});
                send2(16'h4444, 6'd0, o, v);
                check("delay0_max", {15'd0, v, o}, {15'd0, 1'b1, 16'h1002});
                check("wr_ptr_wrap_mem0", {16'd0, mem2[0]}, 32'h2222);
            end
        join

        wp = 16'd0;
        for (int n = 0; n < 13; n++) begin
            apply1(n, tbl[n], wp);
            wp = wp + 16'd1;
        end

        // second strobe one cycle after accept is dropped and flagged
        s_in1 = 16'h0555; dly1 = 16'd1; fb1 = 1'b0; s_vld1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in1 = 16'h0666;
        @(posedge clk);
        @(negedge clk);
        s_vld1 = 1'b0;
        check("overrun_pulse", {31'd0, ovr1}, 32'd1);
        @(negedge clk);
        check("overrun_cleared", {31'd0, ovr1}, 32'd0);
        @(negedge clk);
        check("ovr_seq_out", {15'd0, ovld1, osmp1}, {15'd0, 1'b1, 16'h7FFF});
        wp = wp + 16'd1;
        ov = '{16'h0000, 16'd1, 1'b0, 16'h0555, 16'h0000};
        apply1(13, ov, wp);

        // reset asserted while the FSM sits in RDCAP
        s_in1 = 16'h0777; dly1 = 16'd1; fb1 = 1'b0; s_vld1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_vld1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_rdcap_addr", {16'd0, mif1.addr}, 32'h000E);
        resetn = 1'b0;
        #1;
        check("midrst_ready",      {31'd0, rdy1},  32'd0);
        check("midrst_out_valid",  {31'd0, ovld1}, 32'd0);
        check("midrst_out_sample", {16'd0, osmp1}, 32'd0);
        check("midrst_wren",       {31'd0, mif1.wren}, 32'd0);
        check("midrst_addr",       {16'd0, mif1.addr}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("reclear_%0d", i), {14'd0, mif1.wren, rdy1, mif1.addr},
                  {14'd0, 1'b1, 1'b0, i[15:0]});
        end
        check("no_retry_partial_write", {16'd0, mem1[15]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
